// File: rtl/debounce_scen.sv
// debounce_scen: push-button conditioner.
// Two-flop synchroniser, ce-tick debounce FSM, one-clock press pulse (scen)
// and press-plus-auto-repeat pulse train (mcen). All outputs registered.
// Build option: define DEBOUNCE_SCEN_REPEAT_EN to build the REPEAT state and
// auto-repeat; without it HELD simply waits for release and mcen equals scen.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | button released and accepted as released
// PRESS_WAIT   | pb_s high, counting stable ce ticks before accepting press
// HELD         | press accepted; counting ce ticks toward first repeat
// REPEAT       | auto-repeat running, mcen every RPT_PERIOD ce ticks
// RELEASE_WAIT | pb_s low after a press, counting stable ticks to release
// codes 5-7    | illegal, forced back to IDLE on the next clk
module debounce_scen #(
    parameter int DB_TICKS   = 4,
    parameter int RPT_DELAY  = 8,
    parameter int RPT_PERIOD = 2,
    parameter int CW         = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       pb,
    output logic       db_state,
    output logic       scen,
    output logic       mcen,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } state_t;

    // The tick counter must reach the largest terminal count.
    localparam int MAX_AB   = (DB_TICKS > RPT_DELAY) ? DB_TICKS : RPT_DELAY;
    localparam int MAX_TICK = (MAX_AB > RPT_PERIOD) ? MAX_AB : RPT_PERIOD;

    if (MAX_TICK - 1 >= (1 << CW)) begin : g_cw_check
        $error("debounce_scen: CW too narrow for the configured tick counts");
    end

    localparam logic [CW-1:0] DB_LAST = CW'(DB_TICKS - 1);
`ifdef DEBOUNCE_SCEN_REPEAT_EN
    localparam logic [CW-1:0] RPT_DELAY_LAST  = CW'(RPT_DELAY - 1);
    localparam logic [CW-1:0] RPT_PERIOD_LAST = CW'(RPT_PERIOD - 1);
`endif

    logic          sync1;
    logic          pb_s;
    logic [CW-1:0] cnt;
    state_t        state_q;

    // Two-flop synchroniser bringing the raw button into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            pb_s  <= 1'b0;
        end else begin
            sync1 <= pb;
            pb_s  <= sync1;
        end
    end

    // Debounce FSM; a level change on pb_s always wins over a coincident ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt      <= '0;
            db_state <= 1'b0;
            scen     <= 1'b0;
            mcen     <= 1'b0;
        end else begin
            scen <= 1'b0;
            mcen <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pb_s) begin
                        state_q <= PRESS_WAIT;
                        cnt     <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pb_s) begin
                        state_q <= IDLE;
                        cnt     <= '0;
                    end else if (ce) begin
                        if (cnt == DB_LAST) begin
                            state_q  <= HELD;
                            cnt      <= '0;
                            db_state <= 1'b1;
                            scen     <= 1'b1;
                            mcen     <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!pb_s) begin
                        state_q <= RELEASE_WAIT;
                        cnt     <= '0;
                    end
`ifdef DEBOUNCE_SCEN_REPEAT_EN
                    else if (ce) begin
                        if (cnt == RPT_DELAY_LAST) begin
                            state_q <= REPEAT;
                            cnt     <= '0;
                            mcen    <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                end
`ifdef DEBOUNCE_SCEN_REPEAT_EN
                REPEAT: begin
                    if (!pb_s) begin
                        state_q <= RELEASE_WAIT;
                        cnt     <= '0;
                    end else if (ce) begin
                        if (cnt == RPT_PERIOD_LAST) begin
                            cnt  <= '0;
                            mcen <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
`endif
                RELEASE_WAIT: begin
                    if (pb_s) begin
                        // Bounce back up: resume HELD with a fresh repeat timer.
                        state_q <= HELD;
                        cnt     <= '0;
                    end else if (ce) begin
                        if (cnt == DB_LAST) begin
                            state_q  <= IDLE;
                            cnt      <= '0;
                            db_state <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt      <= '0;
                    db_state <= 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_debounce_scen.sv
// tb_debounce_scen: table-driven segments plus hand-written corner sequences
// for debounce_scen with default parameters and ce high one clk in four.
module tb_debounce_scen;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       ce    = 1'b0;
    logic       pb    = 1'b0;
    logic       db_state;
    logic       scen;
    logic       mcen;
    logic [2:0] state;

    int errors  = 0;
    int checks  = 0;
    int phase   = 0;
    int n_scen  = 0;
    int n_mcen  = 0;
    int n_db_lo = 0;

`ifdef DEBOUNCE_SCEN_REPEAT_EN
    localparam int RPT_END_ST = 3;
    localparam int RPT_NM     = 8;
`else
    localparam int RPT_END_ST = 2;
    localparam int RPT_NM     = 1;
`endif

    debounce_scen dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .pb       (pb),
        .db_state (db_state),
        .scen     (scen),
        .mcen     (mcen),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pb;
        logic rst;
        int   ncyc;
        int   st;
        int   db;
        int   ns;
        int   nm;
        int   dblo;
    } seg_t;

    seg_t segs[8];
    seg_t sb_seg[$];
    logic sb_bit[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        n_scen  = 0;
        n_mcen  = 0;
        n_db_lo = 0;
    endtask

    // One clk: drive inputs, ce from the free-running 1-in-4 phase, sample #1 after the edge.
    task automatic cyc(input logic p, input logic r);
        pb    = p;
        reset = r;
        ce    = (phase == 0);
        phase = (phase + 1) % 4;
        @(posedge clk);
        #1;
        n_scen  += int'(scen);
        n_mcen  += int'(mcen);
        n_db_lo += int'(!db_state);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_t e;
        int   nce;
        int   hit;
        logic ce_now;
        logic eb;

        segs[0] = '{pb:1'b0, rst:1'b1, ncyc:4,  st:0,          db:0, ns:0, nm:0,      dblo:-1};
        segs[1] = '{pb:1'b0, rst:1'b0, ncyc:8,  st:0,          db:0, ns:0, nm:0,      dblo:-1};
        segs[2] = '{pb:1'b1, rst:1'b0, ncyc:97, st:RPT_END_ST, db:1, ns:1, nm:RPT_NM, dblo:16};
        segs[3] = '{pb:1'b0, rst:1'b0, ncyc:40, st:0,          db:0, ns:0, nm:0,      dblo:-1};
        segs[4] = '{pb:1'b1, rst:1'b0, ncyc:24, st:2,          db:1, ns:1, nm:1,      dblo:-1};
        segs[5] = '{pb:1'b0, rst:1'b0, ncyc:8,  st:4,          db:1, ns:0, nm:0,      dblo:0};
        segs[6] = '{pb:1'b1, rst:1'b0, ncyc:4,  st:2,          db:1, ns:0, nm:0,      dblo:0};
        segs[7] = '{pb:1'b0, rst:1'b0, ncyc:24, st:0,          db:0, ns:0, nm:0,      dblo:-1};

        // Table segments: reset, auto-repeat press, release, release glitch.
        for (int s = 0; s < 8; s++) begin
            sb_seg.push_back(segs[s]);
            clr_counts();
            for (int k = 0; k < segs[s].ncyc; k++) cyc(segs[s].pb, segs[s].rst);
            e = sb_seg.pop_front();
            chk($sformatf("seg%0d_state", s), int'(state), e.st);
            chk($sformatf("seg%0d_db", s), int'(db_state), e.db);
            chk($sformatf("seg%0d_scen_cnt", s), n_scen, e.ns);
            chk($sformatf("seg%0d_mcen_cnt", s), n_mcen, e.nm);
            if (e.dblo >= 0) chk($sformatf("seg%0d_db_low_cycles", s), n_db_lo, e.dblo);
        end

        // Reset while HELD with pb high and ce running.
        for (int k = 0; k < 24; k++) cyc(1'b1, 1'b0);
        chk("pre_reset_held", int'(state), 2);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1);
            chk("rst_state", int'(state), 0);
            chk("rst_db", int'(db_state), 0);
            chk("rst_scen", int'(scen), 0);
            chk("rst_mcen", int'(mcen), 0);
        end
        cyc(1'b1, 1'b0);
        chk("rel1_state", int'(state), 0);
        cyc(1'b1, 1'b0);
        chk("rel2_state", int'(state), 0);
        cyc(1'b1, 1'b0);
        chk("rel3_state_pw", int'(state), 1);

        // Bring PRESS_WAIT to cnt==3, then reset on a cycle carrying ce.
        clr_counts();
        nce = 0;
        for (int k = 0; k < 20 && nce < 3; k++) begin
            if (phase == 0) nce++;
            cyc(1'b1, 1'b0);
        end
        chk("pw_ce_count", nce, 3);
        chk("pw_hold_state", int'(state), 1);
        for (int k = 0; k < 8 && phase != 0; k++) cyc(1'b1, 1'b0);
        chk("ce_align", phase, 0);
        cyc(1'b1, 1'b1);
        chk("midq_state", int'(state), 0);
        chk("midq_scen", int'(scen), 0);
        chk("midq_mcen", int'(mcen), 0);
        chk("midq_cnt", int'(dut.cnt), 0);
        chk("midq_scen_total", n_scen, 0);

        // Clean press after reset release: exact pulse cycle via scoreboard queue.
        nce = 0;
        hit = 0;
        for (int j = 1; j <= 30; j++) begin
            ce_now = (phase == 0);
            eb = 1'b0;
            if (j >= 4 && ce_now && hit == 0) begin
                nce++;
                if (nce == 4) begin
                    eb  = 1'b1;
                    hit = 1;
                end
            end
            sb_bit.push_back(eb);
            cyc(1'b1, 1'b0);
            eb = sb_bit.pop_front();
            chk($sformatf("press_scen_c%0d", j), int'(scen), int'(eb));
            chk($sformatf("press_mcen_c%0d", j), int'(mcen), int'(eb));
        end
        chk("press_state", int'(state), 2);
        chk("press_db", int'(db_state), 1);

        // Bounce: pb toggles every 3 clk for 40 clk, then holds high.
        for (int k = 0; k < 24; k++) cyc(1'b0, 1'b0);
        chk("pre_bounce_idle", int'(state), 0);
        clr_counts();
        for (int i = 0; i < 40; i++) cyc(((i % 6) < 3) ? 1'b1 : 1'b0, 1'b0);
        chk("bounce_scen", n_scen, 0);
        chk("bounce_mcen", n_mcen, 0);
        chk("bounce_db_low", n_db_lo, 40);
        clr_counts();
        for (int k = 0; k < 30; k++) cyc(1'b1, 1'b0);
        chk("stable_scen", n_scen, 1);
        chk("stable_mcen", n_mcen, 1);
        chk("stable_state", int'(state), 2);
        chk("stable_db", int'(db_state), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
